// File: rtl/iop408_pkg.sv
//------------------------------------------------------------------------------
// Module : iop408_pkg
// Brief  : Shared types and constants for the IOP408 bus interface unit.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package iop408_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SRAM_ACC = 2'd1,
    EXT_REQ  = 2'd2,
    DONE     = 2'd3
  } state_e;

  typedef enum logic {
    TGT_SRAM = 1'b0,
    TGT_EXT  = 1'b1
  } target_e;

  localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

endpackage : iop408_pkg

`default_nettype wire

// File: rtl/biu408.sv
//------------------------------------------------------------------------------
// Module : biu408
// Brief  : Latches one CPU byte request, routes it to local SRAM or the
//          external bus, and returns data with a one-cycle rdy strobe.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module biu408
  import iop408_pkg::*;
#(
  parameter int SRAM_AW = 12,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        addr,
  input  logic [7:0]         wdata,
  input  logic               read,
  input  logic               write,
  output logic [7:0]         rdata,
  output logic               rdy,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [7:0]         sram_wdata,
  input  logic [7:0]         sram_rdata,
  output logic               ext_req,
  output logic               ext_we,
  output logic [15:0]        ext_addr,
  output logic [7:0]         ext_wdata,
  input  logic               ext_ack,
  input  logic [7:0]         ext_rdata,
  output logic               bus_err,
  input  logic               err_clr
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  target_e         tgt_q, tgt_d;
  logic            we_q, we_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            bus_err_q, bus_err_d;
  logic            sram_rd_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= TGT_SRAM;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    // A timeout in the same cycle overrides the clear below.
    bus_err_d = err_clr ? 1'b0 : bus_err_q;

    case (state_q)
      IDLE: begin
        if (read || write) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = write;
          tgt_d   = ((addr >> SRAM_AW) == 16'd0) ? TGT_SRAM : TGT_EXT;
          cnt_d   = '0;
          state_d = (tgt_d == TGT_SRAM) ? SRAM_ACC : EXT_REQ;
        end
      end
      SRAM_ACC: state_d = DONE;
      EXT_REQ: begin
        cnt_d = cnt_q + TO_W'(1);
        if (ext_ack) begin
          if (!we_q) rdata_d = ext_rdata;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          if (!we_q) rdata_d = BUS_ERR_DATA;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (sram_rd_done) rdata_d = sram_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM data arrives during DONE, so it is bypassed straight to the CPU.
  assign sram_rd_done = (state_q == DONE) && (tgt_q == TGT_SRAM) && !we_q;
  assign rdata        = sram_rd_done ? sram_rdata : rdata_q;
  assign rdy          = (state_q == DONE);
  assign bus_err      = bus_err_q;

  assign sram_en    = (state_q == SRAM_ACC);
  assign sram_we    = sram_en && we_q;
  assign sram_addr  = sram_en ? addr_q[SRAM_AW-1:0] : '0;
  assign sram_wdata = sram_en ? wdata_q : 8'h00;

  assign ext_req   = (state_q == EXT_REQ);
  assign ext_we    = ext_req && we_q;
  assign ext_addr  = ext_req ? addr_q : 16'h0000;
  assign ext_wdata = ext_req ? wdata_q : 8'h00;

endmodule : biu408

`default_nettype wire

// File: tb/tb_biu408.sv
//------------------------------------------------------------------------------
// Module : tb_biu408
// Brief  : Scoreboard bench for biu408 with directed accesses.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_biu408;

  localparam int SRAM_AW = 12;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        addr;
  logic [7:0]         wdata;
  logic               read, write;
  logic [7:0]         rdata;
  logic               rdy;
  logic               sram_en, sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [7:0]         sram_wdata;
  logic [7:0]         sram_rdata;
  logic               ext_req, ext_we;
  logic [15:0]        ext_addr;
  logic [7:0]         ext_wdata;
  logic               ext_ack;
  logic [7:0]         ext_rdata;
  logic               bus_err;
  logic               err_clr;

  biu408 #(.SRAM_AW(SRAM_AW), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read(read), .write(write),
    .rdata(rdata), .rdy(rdy), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata), .bus_err(bus_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle registered read.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [7:0]  rd;
    logic        err;
    int          cyc;
    bit          sram;
    bit          we;
    logic [15:0] a;
    logic [7:0]  wd;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks target-side activity against the pending transaction and
  // pops it when rdy appears.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_en) begin
        if (q.size() == 0) chk("sram_en_spurious", 1, 0);
        else begin
          chk("sram_tgt", 1, {31'd0, q[0].sram});
          chk("sram_we", {31'd0, sram_we}, {31'd0, q[0].we});
          chk("sram_addr", {20'd0, sram_addr}, {20'd0, q[0].a[11:0]});
          if (q[0].we) chk("sram_wdata", {24'd0, sram_wdata}, {24'd0, q[0].wd});
        end
      end
      if (ext_req && q.size() != 0) begin
        chk("ext_tgt", 0, {31'd0, q[0].sram});
        chk("ext_we", {31'd0, ext_we}, {31'd0, q[0].we});
        chk("ext_addr", {16'd0, ext_addr}, {16'd0, q[0].a});
        if (q[0].we) chk("ext_wdata", {24'd0, ext_wdata}, {24'd0, q[0].wd});
      end
      if (rdy) begin
        if (q.size() == 0) chk("rdy_spurious", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rdy_cycle", cyc, e.cyc);
          chk("rdata", {24'd0, rdata}, {24'd0, e.rd});
          chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
        end
      end
    end
  end

  // waits < 0 means the external side never acknowledges.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [7:0] wd, input int waits, input logic [7:0] erd,
                        input logic [7:0] exp_rd, input bit exp_err);
    exp_t e;
    int   acc, g;
    @(negedge clk);
    acc    = cyc + 1;
    e.rd   = exp_rd;
    e.err  = exp_err;
    e.sram = (a < 16'h1000);
    e.we   = wr;
    e.a    = a;
    e.wd   = wd;
    if (e.sram)        e.cyc = acc + 1;
    else if (waits >= 0) e.cyc = acc + 1 + waits;
    else               e.cyc = acc + TIMEOUT;
    q.push_back(e);
    addr  = a;
    wdata = wd;
    read  = rd;
    write = wr;
    if (!e.sram && waits >= 0) begin
      repeat (waits + 1) @(negedge clk);
      ext_ack   = 1'b1;
      ext_rdata = erd;
      @(negedge clk);
      ext_ack   = 1'b0;
      ext_rdata = 8'h00;
    end
    g = 0;
    while (!rdy && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!rdy) chk("rdy_timeout", 0, 1);
    read  = 1'b0;
    write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'h5A;
    mem[12'h000] = 8'h3C;
    sram_rdata = 8'h00;
    rst = 1'b1; addr = 16'h0; wdata = 8'h0; read = 1'b0; write = 1'b0;
    ext_ack = 1'b0; ext_rdata = 8'h00; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_rdy", {31'd0, rdy}, 0);
    chk("rst_ext_req", {31'd0, ext_req}, 0);
    chk("rst_sram_en", {31'd0, sram_en}, 0);
    chk("rst_bus_err", {31'd0, bus_err}, 0);

    access(1, 0, 16'h0010, 8'h00, 0, 8'h00, 8'h5A, 0);
    access(0, 1, 16'h0FFF, 8'hC3, 0, 8'h00, 8'h5A, 0);
    access(1, 0, 16'h0FFF, 8'h00, 0, 8'h00, 8'hC3, 0);
    // Ack after 3 waits coincides with the TIMEOUT-1 count: ack must win.
    access(1, 0, 16'h8001, 8'h00, 3, 8'h42, 8'h42, 0);
    access(1, 0, 16'hFFFF, 8'h00, 0, 8'h99, 8'h99, 0);
    access(1, 0, 16'h1000, 8'h00, -1, 8'h00, 8'hFF, 1);
    chk("err_sticky", {31'd0, bus_err}, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, bus_err}, 0);
    access(0, 1, 16'h2000, 8'h77, 1, 8'hAB, 8'hFF, 0);

    // Reset in the middle of an external access: no rdy, bus released.
    @(negedge clk);
    addr = 16'h4000; read = 1'b1;
    @(negedge clk);
    chk("pre_rst_ext_req", {31'd0, ext_req}, 1);
    rst = 1'b1; read = 1'b0;
    @(negedge clk);
    chk("midrst_ext_req", {31'd0, ext_req}, 0);
    chk("midrst_rdy", {31'd0, rdy}, 0);
    chk("midrst_rdata", {24'd0, rdata}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ext_req", {31'd0, ext_req}, 0);

    access(1, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h3C, 0);
    access(1, 1, 16'h0020, 8'h11, 0, 8'h00, 8'h3C, 0);
    access(1, 0, 16'h0020, 8'h00, 0, 8'h00, 8'h11, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_biu408

`default_nettype wire
